// File: rtl/rp_8bit_tmr_pkg.sv
// rp_8bit_tmr shared definitions: register offsets, clock-select codes, TCCR layout.
// Pure declarations; no logic and no latency.
package rp_8bit_tmr_pkg;

    localparam logic [2:0] OFF_TCCR  = 3'd0;
    localparam logic [2:0] OFF_TCNT  = 3'd1;
    localparam logic [2:0] OFF_OCR   = 3'd2;
    localparam logic [2:0] OFF_TIMSK = 3'd3;
    localparam logic [2:0] OFF_TIFR  = 3'd4;

    typedef enum logic [2:0] {
        CS_STOP    = 3'd0,
        CS_DIV1    = 3'd1,
        CS_DIV8    = 3'd2,
        CS_DIV64   = 3'd3,
        CS_DIV256  = 3'd4,
        CS_DIV1024 = 3'd5
    } cs_e;

    // Bit 0 of TIFR/TIMSK is the overflow source, bit 1 the compare source.
    localparam bit TIFR_TOV_BIT = 1'b0;
    localparam bit TIFR_OCF_BIT = 1'b1;

    // Writable TCCR bits: CS[2:0] and CTC; the upper nibble always reads 0.
    localparam logic [7:0] TCCR_WMASK = 8'h0F;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       ctc;
        logic [2:0] cs;
    } tccr_t;

    function automatic logic [7:0] merge8(input logic [7:0] old_val,
                                          input logic [7:0] wdt,
                                          input logic [7:0] msk);
        return (wdt & msk) | (old_val & ~msk);
    endfunction

endpackage

// File: rtl/rp_8bit_tmr_psc.sv
// 10-bit prescaler producing a one-cycle counter tick for the selected divide ratio.
// tick is combinational from the prescaler state; clr restarts the division.
module rp_8bit_tmr_psc
    import rp_8bit_tmr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cs,
    input  logic       clr,
    output logic       tick
);

    logic [9:0] r_psc;
    logic       w_run;

    always_comb begin
        w_run = 1'b0;
        tick  = 1'b0;
        case (cs)
            CS_DIV1:    begin w_run = 1'b1; tick = 1'b1;          end
            CS_DIV8:    begin w_run = 1'b1; tick = &r_psc[2:0];   end
            CS_DIV64:   begin w_run = 1'b1; tick = &r_psc[5:0];   end
            CS_DIV256:  begin w_run = 1'b1; tick = &r_psc[7:0];   end
            CS_DIV1024: begin w_run = 1'b1; tick = &r_psc[9:0];   end
            default:    begin w_run = 1'b0; tick = 1'b0;          end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc <= 10'd0;
        end else if (clr || !w_run) begin
            r_psc <= 10'd0;
        end else begin
            r_psc <= r_psc + 10'd1;
        end
    end

endmodule

// File: rtl/rp_8bit_tmr.sv
// 8-bit timer on the rp_8bit I/O bus: prescaler, normal/CTC counter, OVF/CMP flags and irq.
// Reads return one cycle after io_ren; no backpressure. RP_8BIT_TMR_PWM_EN adds the pwm output.
module rp_8bit_tmr
    import rp_8bit_tmr_pkg::*;
#(
    parameter logic [5:0] BASE    = 6'h20,
    parameter int         IRQ_OVF = 0,
    parameter int         IRQ_CMP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [1:0] irq_req,
    input  logic [1:0] irq_ack
`ifdef RP_8BIT_TMR_PWM_EN
    ,
    output logic       pwm
`endif
);

    tccr_t      r_tccr;
    logic [7:0] r_tcnt;
    logic [7:0] r_ocr;
    logic [1:0] r_timsk;
    logic [1:0] r_tifr;
    logic [7:0] r_rdt;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr;
    logic       w_wr_tccr;
    logic       w_wr_tcnt;
    logic       w_wr_ocr;
    logic       w_wr_timsk;
    logic       w_wr_tifr;
    tccr_t      w_tccr_new;
    logic       w_cs_chg;
    logic       w_tick;
    logic       w_cnt_tick;
    logic       w_match;
    logic       w_top;
    logic [1:0] w_set;
    logic [1:0] w_clr;
    logic [7:0] w_rd_val;

    assign w_hit      = (io_adr[5:3] == BASE[5:3]);
    assign w_off      = io_adr[2:0];
    assign w_wr       = io_wen & w_hit;
    assign w_wr_tccr  = w_wr && (w_off == OFF_TCCR);
    assign w_wr_tcnt  = w_wr && (w_off == OFF_TCNT);
    assign w_wr_ocr   = w_wr && (w_off == OFF_OCR);
    assign w_wr_timsk = w_wr && (w_off == OFF_TIMSK);
    assign w_wr_tifr  = w_wr && (w_off == OFF_TIFR);

    assign w_tccr_new = tccr_t'(merge8(r_tccr, io_wdt, io_msk) & TCCR_WMASK);
    assign w_cs_chg   = w_wr_tccr && (w_tccr_new.cs != r_tccr.cs);

    rp_8bit_tmr_psc u_psc (
        .clk  (clk),
        .rst  (rst),
        .cs   (r_tccr.cs),
        .clr  (w_cs_chg),
        .tick (w_tick)
    );

    // A CPU write to TCNT swallows the tick entirely: no increment, no flags.
    assign w_cnt_tick = w_tick & ~w_wr_tcnt;
    assign w_match    = (r_tcnt == r_ocr);
    assign w_top      = (r_tcnt == 8'hFF);
    assign w_set      = {w_cnt_tick & w_match, w_cnt_tick & w_top};
    assign w_clr      = (w_wr_tifr ? (io_wdt[1:0] & io_msk[1:0]) : 2'b00) | irq_ack;

    always_comb begin
        w_rd_val = 8'h00;
        case (w_off)
            OFF_TCCR:  w_rd_val = r_tccr;
            OFF_TCNT:  w_rd_val = r_tcnt;
            OFF_OCR:   w_rd_val = r_ocr;
            OFF_TIMSK: w_rd_val = {6'h00, r_timsk};
            OFF_TIFR:  w_rd_val = {6'h00, r_tifr};
            default:   w_rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tccr  <= '0;
            r_tcnt  <= 8'h00;
            r_ocr   <= 8'h00;
            r_timsk <= 2'b00;
            r_tifr  <= 2'b00;
            r_rdt   <= 8'h00;
        end else begin
            if (w_wr_tccr) begin
                r_tccr <= w_tccr_new;
            end
            if (w_wr_tcnt) begin
                r_tcnt <= merge8(r_tcnt, io_wdt, io_msk);
            end else if (w_cnt_tick) begin
                r_tcnt <= ((r_tccr.ctc & w_match) | w_top) ? 8'h00 : r_tcnt + 8'd1;
            end
            if (w_wr_ocr) begin
                r_ocr <= merge8(r_ocr, io_wdt, io_msk);
            end
            if (w_wr_timsk) begin
                r_timsk <= (io_wdt[1:0] & io_msk[1:0]) | (r_timsk & ~io_msk[1:0]);
            end
            // Hardware set dominates any simultaneous clear.
            r_tifr <= (r_tifr & ~w_clr) | w_set;
            // Non-hitting reads return 0 so peripheral read buses can be OR-ed.
            r_rdt  <= (io_ren & w_hit) ? w_rd_val : 8'h00;
        end
    end

    assign io_rdt = r_rdt;
    assign irq_req[IRQ_OVF[0]] = r_tifr[TIFR_TOV_BIT] & r_timsk[TIFR_TOV_BIT];
    assign irq_req[IRQ_CMP[0]] = r_tifr[TIFR_OCF_BIT] & r_timsk[TIFR_OCF_BIT];

`ifdef RP_8BIT_TMR_PWM_EN
    logic r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_tccr.cs != CS_STOP) && (r_tcnt < r_ocr);
        end
    end

    assign pwm = r_pwm;
`endif

endmodule

// File: tb/tb_rp_8bit_tmr.sv
// Bench for rp_8bit_tmr: directed scenarios plus random bus traffic against a cycle model.
module tb_rp_8bit_tmr;

    localparam logic [5:0] BASE = 6'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_wen;
    logic       io_ren;
    logic [5:0] io_adr;
    logic [7:0] io_wdt;
    logic [7:0] io_msk;
    logic [7:0] io_rdt;
    logic [1:0] irq_req;
    logic [1:0] irq_ack;
`ifdef RP_8BIT_TMR_PWM_EN
    logic       pwm;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [2:0] m_cs;
    logic       m_ctc;
    logic [7:0] m_tcnt;
    logic [7:0] m_ocr;
    logic [1:0] m_timsk;
    logic [1:0] m_tifr;
    logic [7:0] m_rdt;
    logic       m_pwm;
    int         m_psc;
    int         div_tab[6] = '{0, 1, 8, 64, 256, 1024};

    rp_8bit_tmr #(.BASE(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_ren  (io_ren),
        .io_adr  (io_adr),
        .io_wdt  (io_wdt),
        .io_msk  (io_msk),
        .io_rdt  (io_rdt),
        .irq_req (irq_req),
        .irq_ack (irq_ack)
`ifdef RP_8BIT_TMR_PWM_EN
        ,
        .pwm     (pwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cs = 3'd0; m_ctc = 1'b0; m_tcnt = 8'h00; m_ocr = 8'h00;
        m_timsk = 2'b00; m_tifr = 2'b00; m_rdt = 8'h00; m_pwm = 1'b0; m_psc = 0;
    endtask

    function automatic logic [7:0] reg_val(input logic [2:0] off);
        case (off)
            3'd0:    return {4'h0, m_ctc, m_cs};
            3'd1:    return m_tcnt;
            3'd2:    return m_ocr;
            3'd3:    return {6'h00, m_timsk};
            3'd4:    return {6'h00, m_tifr};
            default: return 8'h00;
        endcase
    endfunction

    // One clock of the timer, computed from the pre-edge state and the current bus inputs.
    task automatic model_step();
        int         div;
        bit         hit, wr, tick, set_ovf, set_cmp;
        logic [2:0] off;
        logic [7:0] mv, n_tcnt, n_ocr;
        logic [2:0] n_cs;
        logic       n_ctc;
        logic [1:0] n_timsk, clr;
        int         n_psc;

        hit  = (io_adr[5:3] == BASE[5:3]);
        off  = io_adr[2:0];
        wr   = io_wen && hit;
        mv   = (io_wdt & io_msk) | (reg_val(off) & ~io_msk);
        div  = (m_cs <= 3'd5) ? div_tab[m_cs] : 0;
        tick = (div != 0) && (((m_psc + 1) % div) == 0);
        n_psc = (div != 0) ? (m_psc + 1) % 1024 : 0;

        n_cs = m_cs; n_ctc = m_ctc; n_tcnt = m_tcnt; n_ocr = m_ocr; n_timsk = m_timsk;
        set_ovf = 0; set_cmp = 0; clr = irq_ack;

        if (tick && !(wr && off == 3'd1)) begin
            set_cmp = (m_tcnt == m_ocr);
            set_ovf = (m_tcnt == 8'hFF);
            if ((m_ctc && m_tcnt == m_ocr) || m_tcnt == 8'hFF) n_tcnt = 8'h00;
            else n_tcnt = m_tcnt + 8'd1;
        end
        if (wr) begin
            case (off)
                3'd0: begin
                    n_cs = mv[2:0]; n_ctc = mv[3];
                    if (n_cs != m_cs) n_psc = 0;
                end
                3'd1: n_tcnt  = mv;
                3'd2: n_ocr   = mv;
                3'd3: n_timsk = mv[1:0];
                3'd4: clr     = clr | (io_wdt[1:0] & io_msk[1:0]);
                default: ;
            endcase
        end

        m_rdt  = (io_ren && hit) ? reg_val(off) : 8'h00;
        m_pwm  = (m_cs != 3'd0) && (m_tcnt < m_ocr);
        m_tifr = (m_tifr & ~clr) | {set_cmp, set_ovf};
        m_cs = n_cs; m_ctc = n_ctc; m_tcnt = n_tcnt; m_ocr = n_ocr; m_timsk = n_timsk;
        m_psc = n_psc;
    endtask

    task automatic cycle(input logic w, input logic r, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] m, input logic [1:0] k);
        io_wen = w; io_ren = r; io_adr = a; io_wdt = d; io_msk = m; irq_ack = k;
        @(posedge clk);
        model_step();
        #1;
        chk("rdt", io_rdt, m_rdt);
        chk("irq", {6'h00, irq_req}, {6'h00, m_tifr & m_timsk});
`ifdef RP_8BIT_TMR_PWM_EN
        chk("pwm", {7'h00, pwm}, {7'h00, m_pwm});
`endif
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d, input logic [7:0] m = 8'hFF);
        cycle(1'b1, 1'b0, {BASE[5:3], off}, d, m, 2'b00);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, BASE, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] v);
        cycle(1'b0, 1'b1, {BASE[5:3], off}, 8'h00, 8'h00, 2'b00);
        v = io_rdt;
    endtask

    task automatic ack(input logic [1:0] k);
        cycle(1'b0, 1'b0, BASE, 8'h00, 8'h00, k);
    endtask

    task automatic do_reset();
        io_wen = 1'b0; io_ren = 1'b0; irq_ack = 2'b00;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_rdt", io_rdt, 8'h00);
        chk("rst_irq", {6'h00, irq_req}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int n;

        rst = 1'b1;
        io_wen = 1'b0; io_ren = 1'b0; io_adr = BASE; io_wdt = 8'h00; io_msk = 8'h00;
        irq_ack = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_irq", {6'h00, irq_req}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk("reset_read", v, 8'h00);
        end

        // Overflow from 0xFD at divide-by-1, then acknowledge
        wr(3'd0, 8'h01);
        wr(3'd3, 8'h01);
        wr(3'd1, 8'hFD);
        idle(); idle();
        chk("ovf_not_yet", {6'h00, irq_req}, 8'h00);
        idle();
        chk("ovf_irq", {6'h00, irq_req}, 8'h01);
        rd(3'd1, v);
        chk("ovf_tcnt", v, 8'h00);
        ack(2'b01);
        chk("ovf_ack", {6'h00, irq_req}, 8'h00);

        // CTC, divide-by-8, OCR=3: compare every 32 clocks
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h02);
        wr(3'd4, 8'h03);
        wr(3'd0, 8'h0A);
        n = 0;
        do begin idle(); n++; end while (irq_req[1] !== 1'b1 && n < 200);
        chk("ctc_first", 8'(n), 8'd32);
        ack(2'b10);
        n = 0;
        do begin idle(); n++; end while (irq_req[1] !== 1'b1 && n < 200);
        chk("ctc_period", 8'(n), 8'd31);
        for (int k = 0; k < 5; k++) begin
            rd(3'd1, v);
            chk("ctc_seq", v, 8'(k % 4));
            repeat (7) idle();
        end
        rd(3'd4, v);
        chk("ctc_no_tov", v & 8'h01, 8'h00);

        // Masked write touches only CTC; prescaler stays stopped
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h55);
        wr(3'd0, 8'hFF, 8'h08);
        rd(3'd0, v);
        chk("mask_tccr", v, 8'h08);
        repeat (20) idle();
        rd(3'd1, v);
        chk("mask_hold", v, 8'h55);

        // Set beats a simultaneous write-1-to-clear; plain clear works
        wr(3'd0, 8'h01);
        wr(3'd3, 8'h01);
        wr(3'd4, 8'h03);
        wr(3'd1, 8'hFF);
        idle();
        chk("tov_set", {6'h00, irq_req}, 8'h01);
        wr(3'd1, 8'hFF);
        wr(3'd4, 8'h01, 8'h01);
        chk("set_wins", {6'h00, irq_req}, 8'h01);
        wr(3'd0, 8'h00);
        wr(3'd4, 8'h01, 8'h01);
        chk("w1c", {6'h00, irq_req}, 8'h00);

        // CPU write to TCNT on a tick cycle wins over the increment
        wr(3'd2, 8'h40);
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h10);
        idle();
        wr(3'd1, 8'h80);
        rd(3'd1, v);
        chk("tcnt_wr_wins", v, 8'h80);
        rd(3'd1, v);
        chk("tcnt_next", v, 8'h81);
`ifdef RP_8BIT_TMR_PWM_EN
        chk("pwm_low", {7'h00, pwm}, 8'h00);
        wr(3'd1, 8'h10);
        idle();
        chk("pwm_high", {7'h00, pwm}, 8'h01);
`endif

        // Random traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] a;
            logic       w, r;
            logic [7:0] d, m;
            logic [1:0] k;
            if (i == 1500) do_reset();
            w = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {BASE[5:3], 3'($urandom_range(0, 7))};
            d = 8'($urandom);
            m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            k = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            cycle(w, r, a, d, m, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
